// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read-side drain logic.
//   - fifo_state_t : drain FSM state encoding (IDLE, HI, LO)
//   - SYNC_NIBBLE_DEFAULT : default tag placed in the high nibble of first bytes
//   - first_byte() : builds the first byte of a 12-bit sample
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } fifo_state_t;

  localparam logic [3:0] SYNC_NIBBLE_DEFAULT = 4'hA;

  // First byte on the wire: sync tag in the top nibble, sample bits 11:8 below.
  function automatic logic [7:0] first_byte(input logic [3:0] tag, input logic [11:0] s);
    return {tag, s[11:8]};
  endfunction

endpackage

// File: rtl/fifo_drain_tx.sv
// fifo_drain_tx: drains 12-bit samples from a first-word-fall-through FIFO and
// serialises each one as two bytes on a valid/ready byte stream.
//
// Ports
//   clk_i        in   clock, all logic on the rising edge
//   rst_i        in   synchronous active-low reset
//   en_i         in   drain enable
//   r_empty_i    in   FIFO empty flag
//   r_data_i     in   FIFO head word (valid whenever r_empty_i=0)
//   r_inc_o      out  FIFO read increment, one pulse per sample taken
//   tx_data_o    out  byte stream data (8'h00 when tx_valid_o=0)
//   tx_valid_o   out  byte stream valid
//   tx_ready_i   in   byte stream ready
//   burst_done_o out  one-cycle pulse after the last byte of each burst
//
// Handshake: a byte transfers on a rising edge where tx_valid_o=1 and
// tx_ready_i=1. Once tx_valid_o is raised it stays high and tx_data_o stays
// constant until that transfer happens; tx_valid_o never depends on tx_ready_i.
//
// Byte order per sample: {SYNC_NIBBLE, sample[11:8]} then sample[7:0].
module fifo_drain_tx
  import fifo_pkg::*;
#(
  parameter int unsigned BURST_LEN   = 256,
  parameter logic [3:0]  SYNC_NIBBLE = SYNC_NIBBLE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        r_empty_i,
  input  logic [11:0] r_data_i,
  output logic        r_inc_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        burst_done_o
);

  localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);

  fifo_state_t state;
  logic [11:0] sample;
  logic [15:0] burst_cnt;
  logic        take;

  // A new sample is taken from IDLE, or straight out of LO as its second
  // byte leaves, which is what gives one sample every two cycles.
  assign take = en_i & ~r_empty_i &
                ((state == IDLE) | ((state == LO) & tx_ready_i));

  // Gate with reset so the FIFO never advances while the block is held.
  assign r_inc_o = take & rst_i;

  assign tx_valid_o = (state == HI) | (state == LO);

  always_comb begin
    tx_data_o = 8'h00;
    case (state)
      HI:      tx_data_o = first_byte(SYNC_NIBBLE, sample);
      LO:      tx_data_o = sample[7:0];
      default: tx_data_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      sample       <= 12'h000;
      burst_cnt    <= 16'h0000;
      burst_done_o <= 1'b0;
    end else begin
      burst_done_o <= 1'b0;

      if (take) begin
        sample <= r_data_i;
      end

      case (state)
        IDLE: begin
          if (take) begin
            state <= HI;
          end
        end

        HI: begin
          if (tx_ready_i) begin
            state <= LO;
          end
        end

        LO: begin
          if (tx_ready_i) begin
            state <= take ? HI : IDLE;
            // Counter survives enable gaps; only reset clears it.
            if (burst_cnt == BURST_LAST) begin
              burst_cnt    <= 16'h0000;
              burst_done_o <= 1'b1;
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
